// File: rtl/i2c_slave_if.sv
// Parallel-side handshake between the I2C slave and the host logic it serves.
interface i2c_slave_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       rw;

  modport slave  (output rx_data, rx_valid, tx_req, busy, rw, input tx_data);
  modport master (input rx_data, rx_valid, tx_req, busy, rw, output tx_data);
endinterface

// File: rtl/i2c_slave.sv
// I2C slave with a 7-bit address. It oversamples the bus on clk, never stretches SCL,
// and drives SDA open-drain only.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  i2c_slave_if.slave  host
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;

  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
  assign stop_det  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
  assign shift_in  = {shift_q, sda_s};

  assign i2c_sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign host.rx_data   = rx_data_q;
  assign host.rx_valid  = rx_valid_q;
  assign host.tx_req    = tx_req_q;
  assign host.busy      = busy_q;
  assign host.rw        = rw_q;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], i2c_scl};
    sda_sync_d = {sda_sync_q[0], i2c_sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = shift_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7)
            state_d = (shift_q == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
        end
        // sda_oe_q doubles as the "ACK already driven" phase flag in both ACK states
        ADDR_ACK: begin
          if (scl_rise && sda_oe_q && rw_q) tx_req_d = 1'b1;
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              busy_d   = 1'b1;
            end else begin
              bit_cnt_d = '0;
              if (rw_q) begin
                state_d  = RD_DATA;
                shift_d  = host.tx_data[6:0];
                sda_oe_d = ~host.tx_data[7];
              end else begin
                state_d  = WR_DATA;
                sda_oe_d = 1'b0;
              end
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d   = shift_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            state_d    = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WR_DATA;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            state_d  = RD_ACK;
          end else begin
            sda_oe_d  = ~shift_q[6];
            shift_d   = {shift_q[5:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        // a NACK leaves on the rising edge, so any falling edge seen here follows an ACK
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d  = WAIT_STOP;
            else       tx_req_d = 1'b1;
          end
          if (scl_fall) begin
            state_d   = RD_DATA;
            shift_d   = host.tx_data[6:0];
            sda_oe_d  = ~host.tx_data[7];
            bit_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

endmodule
